gauss_filter_imgrd_p: RTL and testbench
=======================================

Name: gauss_filter_imgrd_p

Overview:
Parametrised address scanner for the two-pass separable Gaussian filter. Pass 0 (row pass) scans the source RAM row by row. Pass 1 (column pass) scans the destination RAM column by column. Each line is extended by PAD pixels on both ends for border handling. Compared with the fixed 256x256 / pad-2 scanner, this block adds generic image size and pad, per-pass enable, ready back-pressure, line markers, busy/done status and a reset.

Parameters:
- IMG_W, 256, image width in pixels (>=1)
- IMG_H, 256, image height in pixels (>=1)
- PAD, 2, border pixels on each end of a line (0..8)
- COORD_W, 10, coordinate width, two's complement. Must satisfy 2^(COORD_W-1) > max(IMG_W,IMG_H)+PAD-1; elaboration error otherwise.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to start a frame; sampled only in IDLE
- mode  in  2  bit0 = run row pass, bit1 = run column pass; latched with start
- rd_ready  in  1  downstream accepts the current read request
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at end of frame
- sram_rd_en  out  1  source RAM read request (row pass)
- sram_rd_px  out  COORD_W  x coordinate, range [-PAD, IMG_W-1+PAD]
- sram_rd_py  out  COORD_W  y coordinate, range [0, IMG_H-1]
- dram_rd_en  out  1  destination RAM read request (column pass)
- dram_rd_px  out  COORD_W  x coordinate, range [0, IMG_W-1]
- dram_rd_py  out  COORD_W  y coordinate, range [-PAD, IMG_H-1+PAD]
- rd_sol  out  1  current request is the first element of a line
- rd_eol  out  1  current request is the last element of a line

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - all outputs to 0
  - FSM to IDLE
  - counters to 0
  - mode latch to 0
  - Reset mid-frame aborts immediately; no done pulse is produced.
- FSM states: IDLE, ROW, COL.
- IDLE + start, mode != 0: latch mode. Go to ROW if mode[0], else COL. On the same edge, present the first request.
- IDLE + start, mode == 0: stay IDLE; done=1 for one cycle; no requests.
- start outside IDLE: ignored.
- mode changes after start: ignored.
- Row pass loops:
  - outer loop: line y = 0..IMG_H-1
  - inner loop: x = -PAD..IMG_W-1+PAD
  - outputs: sram_rd_px=x, sram_rd_py=y (zero-extended), sram_rd_en=1
- Column pass loops:
  - outer loop: line x = 0..IMG_W-1
  - inner loop: y = -PAD..IMG_H-1+PAD
  - outputs: dram_rd_px=x (zero-extended), dram_rd_py=y, dram_rd_en=1
- Request/handshake rules:
  - All request outputs are registered.
  - A request transfers on a rising edge where its rd_en=1 and rd_ready=1.
  - While rd_ready=0, every request output and the counters hold stable (no change, no drop).
  - On transfer, the next request is presented on the same edge, so there are no bubbles within a pass.
- Line markers:
  - rd_sol=1 on the inner element -PAD.
  - rd_eol=1 on the inner element N-1+PAD (N = IMG_W for row pass, IMG_H for column pass).
  - Both are 1 when the line length is 1.
  - Both are 0 when no rd_en is high.
- Pass changeover: on transfer of the last row-pass request, if mode[1]=1, the first column-pass request (dram x=0, y=-PAD) is presented on that same edge. sram_rd_en drops and dram_rd_en rises simultaneously; they are never high together.
- End of frame: on transfer of the final request:
  - rd_en drops to 0 and coordinates reset to 0
  - FSM returns to IDLE
  - busy goes to 0 and done goes to 1 for exactly one cycle
  - start is accepted again in the cycle done is high
- busy = (state != IDLE).
- Latency: the first request is visible in the cycle after start is sampled.
- Throughput with rd_ready held high: one request per cycle.
  - Row pass: IMG_H*(IMG_W+2*PAD) requests.
  - Column pass: IMG_W*(IMG_H+2*PAD) requests.
- Arithmetic:
  - Inner counter is a signed COORD_W counter, wrapped explicitly from N-1+PAD to -PAD.
  - Outer counter wraps from last line to 0 and advances the pass.
  - Negative coordinates are two's complement, e.g. -2 = 0x3FE at COORD_W=10.

Test Plan:
- IMG_W=4, IMG_H=3, PAD=1, mode=3, start at cycle T, rd_ready=1:
  - 18 sram requests: (-1,0)..(4,0), (-1,1).., (4,2).
  - Then 20 dram requests: (0,-1)..(0,3), .., (3,3).
  - Requests visible in cycles T+1..T+38; busy high over the same cycles; done=1 in cycle T+39 only.
  - rd_sol on px=-1 / py=-1; rd_eol on px=4 / py=3.
- Same configuration, mode=1: 18 sram requests, no dram requests, done in cycle T+19. Then mode=2: 20 dram requests only, first is (0,0x3FF).
- Back-pressure: rd_ready=0 for 5 cycles while showing request (2,1), and again across the row-to-column changeover.
  - All outputs are stable during each stall.
  - The sequence is unchanged.
  - done is delayed by exactly the number of stall cycles.
- start with mode=0 -> done pulse in the next cycle, no rd_en. start pulsed mid-frame -> ignored, sequence unaffected.
- rst_n low asynchronously during the column pass (between clock edges):
  - All outputs go to 0 immediately, with no done pulse.
  - After release, a start gives a full fresh frame beginning at sram (-1,0).
- Default parameters, mode=3, rd_ready=1:
  - Exactly 66560 sram + 66560 dram requests.
  - First request at px=0x3FE; last sram request (257,255); last dram request (255,257).

Source files
------------

// File: rtl/gauss_filter_imgrd_p_if.sv
// Command, status and read-request bundle for the two-pass Gaussian address scanner.
interface gauss_filter_imgrd_p_if #(
  parameter int unsigned COORD_W = 10
);
  logic               start;
  logic [1:0]         mode;
  logic               rd_ready;
  logic               busy;
  logic               done;
  logic               sram_rd_en;
  logic [COORD_W-1:0] sram_rd_px;
  logic [COORD_W-1:0] sram_rd_py;
  logic               dram_rd_en;
  logic [COORD_W-1:0] dram_rd_px;
  logic [COORD_W-1:0] dram_rd_py;
  logic               rd_sol;
  logic               rd_eol;

  modport master (
    output start, mode, rd_ready,
    input  busy, done, sram_rd_en, sram_rd_px, sram_rd_py,
    input  dram_rd_en, dram_rd_px, dram_rd_py, rd_sol, rd_eol
  );

  modport slave (
    input  start, mode, rd_ready,
    output busy, done, sram_rd_en, sram_rd_px, sram_rd_py,
    output dram_rd_en, dram_rd_px, dram_rd_py, rd_sol, rd_eol
  );
endinterface

// File: rtl/gauss_filter_imgrd_p.sv
// Address scanner for a separable Gaussian filter: row pass over the source RAM,
// then column pass over the destination RAM, each line padded by PAD pixels per end.
module gauss_filter_imgrd_p #(
  parameter int unsigned IMG_W   = 256,
  parameter int unsigned IMG_H   = 256,
  parameter int unsigned PAD     = 2,
  parameter int unsigned COORD_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gauss_filter_imgrd_p_if.slave  bus
);

  localparam int unsigned MAX_DIM = (IMG_W > IMG_H) ? IMG_W : IMG_H;

  if ((IMG_W < 1) || (IMG_H < 1) || (PAD > 8) ||
      ((64'd1 << (COORD_W - 1)) <= 64'(MAX_DIM + PAD - 1))) begin : g_bad_params
    $error("gauss_filter_imgrd_p: invalid IMG_W/IMG_H/PAD/COORD_W combination");
  end

  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
  localparam logic [COORD_W-1:0] X_FIRST  = COORD_W'(0 - PAD);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(IMG_W - 1 + PAD);
  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMG_H - 1 + PAD);
  localparam logic [COORD_W-1:0] W_LAST   = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, ROW, COL} state_e;

  state_e             state_q, state_d;
  logic               col_q, col_d;
  logic [COORD_W-1:0] inner_q, inner_d;
  logic [COORD_W-1:0] line_q, line_d;
  logic               done_d;

  logic               busy_q, busy_d;
  logic               done_q;
  logic               sram_en_q, sram_en_d;
  logic               dram_en_q, dram_en_d;
  logic               sol_q, sol_d;
  logic               eol_q, eol_d;
  logic [COORD_W-1:0] sram_px_q, sram_px_d;
  logic [COORD_W-1:0] sram_py_q, sram_py_d;
  logic [COORD_W-1:0] dram_px_q, dram_px_d;
  logic [COORD_W-1:0] dram_py_q, dram_py_d;

  // Next-state and counter advance; nothing moves while a request is stalled.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    inner_d = inner_q;
    line_d  = line_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.mode == 2'b00) begin
            done_d = 1'b1;
          end else begin
            col_d   = bus.mode[1];
            state_d = bus.mode[0] ? ROW : COL;
            inner_d = X_FIRST;
            line_d  = '0;
          end
        end
      end
      ROW: begin
        if (bus.rd_ready) begin
          if (inner_q != ROW_LAST) begin
            inner_d = inner_q + ONE;
          end else begin
            inner_d = X_FIRST;
            if (line_q != H_LAST) begin
              line_d = line_q + ONE;
            end else begin
              line_d = '0;
              if (col_q) begin
                state_d = COL;
              end else begin
                state_d = IDLE;
                inner_d = '0;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      COL: begin
        if (bus.rd_ready) begin
          if (inner_q != COL_LAST) begin
            inner_d = inner_q + ONE;
          end else begin
            inner_d = X_FIRST;
            if (line_q != W_LAST) begin
              line_d = line_q + ONE;
            end else begin
              state_d = IDLE;
              line_d  = '0;
              inner_d = '0;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        inner_d = '0;
        line_d  = '0;
      end
    endcase

    // Request outputs are a registered image of the next counter state.
    busy_d    = (state_d != IDLE);
    sram_en_d = (state_d == ROW);
    dram_en_d = (state_d == COL);
    sram_px_d = sram_en_d ? inner_d : '0;
    sram_py_d = sram_en_d ? line_d  : '0;
    dram_px_d = dram_en_d ? line_d  : '0;
    dram_py_d = dram_en_d ? inner_d : '0;
    sol_d     = busy_d && (inner_d == X_FIRST);
    eol_d     = (sram_en_d && (inner_d == ROW_LAST)) ||
                (dram_en_d && (inner_d == COL_LAST));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      col_q     <= 1'b0;
      inner_q   <= '0;
      line_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sram_en_q <= 1'b0;
      dram_en_q <= 1'b0;
      sol_q     <= 1'b0;
      eol_q     <= 1'b0;
      sram_px_q <= '0;
      sram_py_q <= '0;
      dram_px_q <= '0;
      dram_py_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      inner_q   <= inner_d;
      line_q    <= line_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sram_en_q <= sram_en_d;
      dram_en_q <= dram_en_d;
      sol_q     <= sol_d;
      eol_q     <= eol_d;
      sram_px_q <= sram_px_d;
      sram_py_q <= sram_py_d;
      dram_px_q <= dram_px_d;
      dram_py_q <= dram_py_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.sram_rd_en = sram_en_q;
  assign bus.sram_rd_px = sram_px_q;
  assign bus.sram_rd_py = sram_py_q;
  assign bus.dram_rd_en = dram_en_q;
  assign bus.dram_rd_px = dram_px_q;
  assign bus.dram_rd_py = dram_py_q;
  assign bus.rd_sol     = sol_q;
  assign bus.rd_eol     = eol_q;

endmodule

// File: tb/tb_gauss_filter_imgrd_p.sv
// Directed bench for gauss_filter_imgrd_p on a 4x3 image with one pixel of padding.
module tb_gauss_filter_imgrd_p;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int P  = 1;
  localparam int CW = 10;
  localparam int NONE = -1;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   err_cnt;

  gauss_filter_imgrd_p_if #(.COORD_W(CW)) bus ();

  gauss_filter_imgrd_p #(
    .IMG_W(W), .IMG_H(H), .PAD(P), .COORD_W(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [45:0] observed();
    return {bus.sram_rd_en, bus.dram_rd_en, bus.rd_sol, bus.rd_eol, bus.busy, bus.done,
            bus.sram_rd_px, bus.sram_rd_py, bus.dram_rd_px, bus.dram_rd_py};
  endfunction

  function automatic logic [45:0] pack(input bit se, input bit de, input bit sol, input bit eol,
                                       input bit busy, input bit done,
                                       input int spx, input int spy, input int dpx, input int dpy);
    return {se, de, sol, eol, busy, done, CW'(spx), CW'(spy), CW'(dpx), CW'(dpy)};
  endfunction

  task automatic chk(input string tag, input logic [45:0] exp);
    logic [45:0] obs;
    obs = observed();
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request: optional stall cycles, then transfer; a: inner coord, b: line index.
  task automatic req(input bit row, input int a, input int b, input int stall, input bit poke);
    logic [45:0] e;
    bit          sol;
    bit          eol;
    string       tag;
    sol = (a == -P);
    eol = row ? (a == W - 1 + P) : (a == H - 1 + P);
    e   = row ? pack(1, 0, sol, eol, 1, 0, a, b, 0, 0) : pack(0, 1, sol, eol, 1, 0, 0, 0, b, a);
    tag = row ? $sformatf("sram(%0d,%0d)", a, b) : $sformatf("dram(%0d,%0d)", b, a);
    for (int i = 0; i < stall; i++) begin
      bus.rd_ready = 1'b0;
      chk({tag, " stalled"}, e);
      @(negedge clk);
    end
    bus.rd_ready = 1'b1;
    if (poke) begin
      bus.start = 1'b1;
      bus.mode  = 2'b00;
    end
    chk(tag, e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Starts a frame at the current negedge and walks the expected request sequence.
  // Returns in the done cycle (done checked), or early once 'limit' requests transferred.
  task automatic frame(input logic [1:0] m, input int sk1, input int sn1, input int sk2,
                       input int sn2, input int pk, input int limit);
    int k;
    k = 0;
    bus.start = 1'b1;
    bus.mode  = m;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = ~m;
    if (m[0]) begin
      for (int y = 0; y < H; y++) begin
        for (int x = -P; x <= W - 1 + P; x++) begin
          if (k == limit) return;
          req(1'b1, x, y, (k == sk1) ? sn1 : ((k == sk2) ? sn2 : 0), k == pk);
          k++;
        end
      end
    end
    if (m[1]) begin
      for (int x = 0; x < W; x++) begin
        for (int y = -P; y <= H - 1 + P; y++) begin
          if (k == limit) return;
          req(1'b0, y, x, (k == sk1) ? sn1 : ((k == sk2) ? sn2 : 0), k == pk);
          k++;
        end
      end
    end
    chk($sformatf("done pulse mode=%0d", m), pack(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk(tag, '0);
  endtask

  initial begin
    clk          = 1'b0;
    vec_cnt      = 0;
    err_cnt      = 0;
    bus.start    = 1'b0;
    bus.mode     = 2'b00;
    bus.rd_ready = 1'b1;
    rst_n        = 1'b1;
    #1 rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset state", '0);
    rst_n = 1'b1;
    idle_chk("idle after reset");

    // Full frame, both passes, no back-pressure.
    frame(2'b11, NONE, 0, NONE, 0, NONE, 1000);
    idle_chk("idle after mode3");

    // Row pass only, then column pass started in the done cycle.
    frame(2'b01, NONE, 0, NONE, 0, NONE, 1000);
    frame(2'b10, NONE, 0, NONE, 0, NONE, 1000);
    idle_chk("idle after mode2");

    // Stall on (2,1) and across the changeover; stray start mid column pass.
    frame(2'b11, 9, 5, 17, 4, 25, 1000);
    idle_chk("idle after stalls");

    // Empty mode: just a done pulse.
    frame(2'b00, NONE, 0, NONE, 0, NONE, 1000);
    idle_chk("idle after mode0");

    // Asynchronous reset during the column pass, then a fresh frame.
    frame(2'b11, NONE, 0, NONE, 0, NONE, 21);
    #2 rst_n = 1'b0;
    #1 chk("async reset mid-frame", '0);
    @(negedge clk);
    chk("no done after reset", '0);
    rst_n = 1'b1;
    idle_chk("idle after release");
    frame(2'b11, NONE, 0, NONE, 0, NONE, 1000);
    idle_chk("idle after fresh frame");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
